id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_if.sv | 59 +++++
 rtl/id_ex_reg.sv | 142 ++++++++++++++
 tb/tb_id_ex_reg.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// Bundle between decode, the ID/EX register, the EX stage and the forwarding
// sources. The register sits on the slave side; the driving environment is
// the master.
interface id_ex_reg_if;
    // decode side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [1:0]  in_src0_sel;
    logic        in_src1_sel;
    logic [4:0]  in_alu_op;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    // pipeline control
    logic        flush;
    logic        ex_ready;
    // forwarding sources
    logic [4:0]  mem_rd;
    logic        mem_wen;
    logic        mem_is_load;
    logic [31:0] mem_res;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_data;
    // execute side
    logic        out_valid;
    logic [31:0] alu_src0;
    logic [31:0] alu_src1;
    logic [4:0]  alu_op;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_is_load;
    logic [31:0] out_pc;
    logic [31:0] out_store_data;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
               in_src0_sel, in_src1_sel, in_alu_op, in_rd, in_wen, in_is_load,
               flush, ex_ready, mem_rd, mem_wen, mem_is_load, mem_res,
               wb_rd, wb_wen, wb_data,
        input  in_ready, out_valid, alu_src0, alu_src1, alu_op, out_rd, out_wen,
               out_is_load, out_pc, out_store_data
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
               in_src0_sel, in_src1_sel, in_alu_op, in_rd, in_wen, in_is_load,
               flush, ex_ready, mem_rd, mem_wen, mem_is_load, mem_res,
               wb_rd, wb_wen, wb_data,
        output in_ready, out_valid, alu_src0, alu_src1, alu_op, out_rd, out_wen,
               out_is_load, out_pc, out_store_data
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: holds one decoded instruction, forwards MEM/WB
// results into its operands, and inserts a bubble on a load-use hazard.
module id_ex_reg (
    input  logic          clk,
    input  logic          rstn,
    id_ex_reg_if.slave    bus
);
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [31:0] rs1_data_q, rs1_data_d;
    logic [31:0] rs2_data_q, rs2_data_d;
    logic [31:0] imm_q, imm_d;
    logic [1:0]  src0_sel_q, src0_sel_d;
    logic        src1_sel_q, src1_sel_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic        is_load_q, is_load_d;

    logic        hazard;
    logic        capture;
    logic        advance;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;

    // Load-use hazard, handshake and operand forwarding (MEM wins over WB, x0 never forwarded).
    always_comb begin
        hazard  = valid_q & bus.mem_wen & bus.mem_is_load & (bus.mem_rd != 5'd0)
                  & ((bus.mem_rd == rs1_q) | (bus.mem_rd == rs2_q));
        bus.in_ready = !valid_q | (bus.ex_ready & !hazard);
        capture = bus.in_valid & bus.in_ready & !bus.flush;
        advance = valid_q & bus.ex_ready & !hazard;

        fwd_rs1 = rs1_data_q;
        if (bus.mem_wen && !bus.mem_is_load && bus.mem_rd == rs1_q && rs1_q != 5'd0)
            fwd_rs1 = bus.mem_res;
        else if (bus.wb_wen && bus.wb_rd == rs1_q && rs1_q != 5'd0)
            fwd_rs1 = bus.wb_data;

        fwd_rs2 = rs2_data_q;
        if (bus.mem_wen && !bus.mem_is_load && bus.mem_rd == rs2_q && rs2_q != 5'd0)
            fwd_rs2 = bus.mem_res;
        else if (bus.wb_wen && bus.wb_rd == rs2_q && rs2_q != 5'd0)
            fwd_rs2 = bus.wb_data;
    end

    // Drive EX: operand muxing, bubble on hazard, write/load flags gated by validity.
    always_comb begin
        bus.out_valid = valid_q & !hazard;
        case (src0_sel_q)
            2'd0:    bus.alu_src0 = fwd_rs1;
            2'd1:    bus.alu_src0 = pc_q;
            default: bus.alu_src0 = 32'd0;
        endcase
        bus.alu_src1       = src1_sel_q ? imm_q : fwd_rs2;
        bus.out_store_data = fwd_rs2;
        bus.alu_op         = alu_op_q;
        bus.out_rd         = rd_q;
        bus.out_pc         = pc_q;
        bus.out_wen        = wen_q & bus.out_valid;
        bus.out_is_load    = is_load_q & bus.out_valid;
    end

    // Next state: capture, drain, or hold while absorbing WB retirements; flush kills validity last.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        src0_sel_d = src0_sel_q;
        src1_sel_d = src1_sel_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        is_load_d  = is_load_q;

        if (capture) begin
            valid_d    = 1'b1;
            pc_d       = bus.in_pc;
            rs1_d      = bus.in_rs1;
            rs2_d      = bus.in_rs2;
            rs1_data_d = bus.in_rs1_data;
            rs2_data_d = bus.in_rs2_data;
            imm_d      = bus.in_imm;
            src0_sel_d = bus.in_src0_sel;
            src1_sel_d = bus.in_src1_sel;
            alu_op_d   = bus.in_alu_op;
            rd_d       = bus.in_rd;
            wen_d      = bus.in_wen;
            is_load_d  = bus.in_is_load;
        end else if (advance) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // A WB result that retires while we stall would otherwise be lost.
            if (bus.wb_wen && bus.wb_rd == rs1_q && rs1_q != 5'd0)
                rs1_data_d = bus.wb_data;
            if (bus.wb_wen && bus.wb_rd == rs2_q && rs2_q != 5'd0)
                rs2_data_d = bus.wb_data;
        end

        if (bus.flush)
            valid_d = 1'b0;
    end

    // State register with synchronous active-low reset clearing every held field.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            src0_sel_q <= '0;
            src1_sel_q <= 1'b0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            is_load_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            src0_sel_q <= src0_sel_d;
            src1_sel_q <= src1_sel_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            is_load_q  <= is_load_d;
        end
    end
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: each step pushes its expected EX-side view
// onto a scoreboard queue, which is popped and compared once outputs settle.
module tb_id_ex_reg;
    logic clk;
    logic rstn;

    id_ex_reg_if bus ();

    id_ex_reg dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        ov;
        logic        ir;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] sd;
        logic [4:0]  op;
        logic        wen;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic ir,
                              input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] sd, input logic [4:0] op,
                              input logic wen, input logic [31:0] pc);
        exp_t e;
        e.tag = tag; e.ov = ov; e.ir = ir; e.s0 = s0; e.s1 = s1;
        e.sd = sd; e.op = op; e.wen = wen; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, e.ov});
            cmp({e.tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, e.ir});
            cmp({e.tag, ".alu_src0"},  bus.alu_src0, e.s0);
            cmp({e.tag, ".alu_src1"},  bus.alu_src1, e.s1);
            cmp({e.tag, ".store"},     bus.out_store_data, e.sd);
            cmp({e.tag, ".alu_op"},    {27'd0, bus.alu_op}, {27'd0, e.op});
            cmp({e.tag, ".out_wen"},   {31'd0, bus.out_wen}, {31'd0, e.wen});
            cmp({e.tag, ".out_pc"},    bus.out_pc, e.pc);
        end
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                               input logic [1:0] sel0, input logic sel1, input logic [4:0] op,
                               input logic [4:0] rd, input logic wen, input logic ld);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_rs1_data = d1;
        bus.in_rs2_data = d2;
        bus.in_imm      = imm;
        bus.in_src0_sel = sel0;
        bus.in_src1_sel = sel1;
        bus.in_alu_op   = op;
        bus.in_rd       = rd;
        bus.in_wen      = wen;
        bus.in_is_load  = ld;
    endtask

    task automatic clear_fwd();
        bus.mem_rd = 5'd0; bus.mem_wen = 1'b0; bus.mem_is_load = 1'b0; bus.mem_res = 32'd0;
        bus.wb_rd = 5'd0;  bus.wb_wen = 1'b0;  bus.wb_data = 32'd0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        bus.flush = 1'b1;
        bus.ex_ready = 1'b1;
        clear_fwd();
        drive_instr(32'hDEAD, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 2'd1, 1'b1, 5'b00010, 5'd4, 1'b1, 1'b1);

        // reset with flush and a valid incoming instruction
        tick();
        expect_out("reset", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        check_out();
        rstn = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
        expect_out("release", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        check_out();

        // pass-through, then drain
        drive_instr(32'h100, 5'd1, 5'd2, 32'd5, 32'd7, 32'h40, 2'd0, 1'b0, 5'b00000, 5'd5, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        expect_out("pass", 1'b1, 1'b1, 32'd5, 32'd7, 32'd7, 5'b00000, 1'b1, 32'h100);
        check_out();
        tick();
        expect_out("drain", 1'b0, 1'b1, 32'd5, 32'd7, 32'd7, 5'b00000, 1'b0, 32'h100);
        check_out();

        // pc/imm select, then back-to-back zero select
        drive_instr(32'h200, 5'd3, 5'd6, 32'h10, 32'h20, 32'h99, 2'd1, 1'b1, 5'b01011, 5'd2, 1'b0, 1'b0);
        tick();
        drive_instr(32'h300, 5'd3, 5'd0, 32'h33, 32'h44, 32'h55, 2'd2, 1'b0, 5'b10000, 5'd3, 1'b1, 1'b1);
        expect_out("sel_pc_imm", 1'b1, 1'b1, 32'h200, 32'h99, 32'h20, 5'b01011, 1'b0, 32'h200);
        check_out();
        tick();
        bus.in_valid = 1'b0;
        expect_out("sel_zero", 1'b1, 1'b1, 32'd0, 32'h44, 32'h44, 5'b10000, 1'b1, 32'h300);
        check_out();

        // forwarding priority on rs1=3, and WB survival while stalled
        drive_instr(32'h400, 5'd3, 5'd9, 32'h30, 32'h90, 32'd0, 2'd0, 1'b0, 5'b00010, 5'd7, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b0;
        bus.mem_rd = 5'd3; bus.mem_wen = 1'b1; bus.mem_res = 32'hAA;
        bus.wb_rd = 5'd3;  bus.wb_wen = 1'b1;  bus.wb_data = 32'hBB;
        expect_out("fwd_mem", 1'b1, 1'b0, 32'hAA, 32'h90, 32'h90, 5'b00010, 1'b1, 32'h400);
        check_out();
        bus.mem_wen = 1'b0;
        expect_out("fwd_wb", 1'b1, 1'b0, 32'hBB, 32'h90, 32'h90, 5'b00010, 1'b1, 32'h400);
        check_out();
        tick();
        clear_fwd();
        expect_out("wb_survive", 1'b1, 1'b0, 32'hBB, 32'h90, 32'h90, 5'b00010, 1'b1, 32'h400);
        check_out();

        // x0 never forwarded nor hazarding
        drive_instr(32'h500, 5'd0, 5'd0, 32'h12, 32'h34, 32'd0, 2'd0, 1'b0, 5'b10010, 5'd0, 1'b0, 1'b0);
        bus.ex_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.mem_rd = 5'd0; bus.mem_wen = 1'b1; bus.mem_is_load = 1'b1; bus.mem_res = 32'hAA;
        bus.wb_rd = 5'd0;  bus.wb_wen = 1'b1;  bus.wb_data = 32'hBB;
        expect_out("x0", 1'b1, 1'b1, 32'h12, 32'h34, 32'h34, 5'b10010, 1'b0, 32'h500);
        check_out();
        clear_fwd();

        // load-use bubble, then WB supplies the loaded value
        drive_instr(32'h600, 5'd1, 5'd4, 32'h100, 32'h400, 32'd0, 2'd0, 1'b0, 5'b00000, 5'd8, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        bus.mem_rd = 5'd4; bus.mem_wen = 1'b1; bus.mem_is_load = 1'b1; bus.mem_res = 32'hEE;
        expect_out("load_use", 1'b0, 1'b0, 32'h100, 32'h400, 32'h400, 5'b00000, 1'b0, 32'h600);
        check_out();
        tick();
        clear_fwd();
        bus.wb_rd = 5'd4; bus.wb_wen = 1'b1; bus.wb_data = 32'h11;
        expect_out("load_wb", 1'b1, 1'b1, 32'h100, 32'h11, 32'h11, 5'b00000, 1'b1, 32'h600);
        check_out();
        tick();
        clear_fwd();
        expect_out("load_drain", 1'b0, 1'b1, 32'h100, 32'h400, 32'h400, 5'b00000, 1'b0, 32'h600);
        check_out();

        // backpressure for three cycles with a WB retirement to rs1
        drive_instr(32'h700, 5'd5, 5'd6, 32'h50, 32'h60, 32'd0, 2'd0, 1'b0, 5'b01010, 5'd9, 1'b1, 1'b0);
        tick();
        bus.ex_ready = 1'b0;
        drive_instr(32'h800, 5'd7, 5'd8, 32'h70, 32'h80, 32'd0, 2'd0, 1'b0, 5'b01001, 5'd10, 1'b1, 1'b0);
        expect_out("bp_c1", 1'b1, 1'b0, 32'h50, 32'h60, 32'h60, 5'b01010, 1'b1, 32'h700);
        check_out();
        bus.wb_rd = 5'd5; bus.wb_wen = 1'b1; bus.wb_data = 32'h22;
        expect_out("bp_c1_wb", 1'b1, 1'b0, 32'h22, 32'h60, 32'h60, 5'b01010, 1'b1, 32'h700);
        check_out();
        tick();
        clear_fwd();
        expect_out("bp_c2", 1'b1, 1'b0, 32'h22, 32'h60, 32'h60, 5'b01010, 1'b1, 32'h700);
        check_out();
        tick();
        expect_out("bp_c3", 1'b1, 1'b0, 32'h22, 32'h60, 32'h60, 5'b01010, 1'b1, 32'h700);
        check_out();
        bus.ex_ready = 1'b1;
        expect_out("bp_release", 1'b1, 1'b1, 32'h22, 32'h60, 32'h60, 5'b01010, 1'b1, 32'h700);
        check_out();
        tick();
        bus.in_valid = 1'b0;
        expect_out("bp_next", 1'b1, 1'b1, 32'h70, 32'h80, 32'h80, 5'b01001, 1'b1, 32'h800);
        check_out();

        // flush kills both held and incoming instruction
        bus.ex_ready = 1'b0;
        drive_instr(32'h900, 5'd1, 5'd2, 32'h91, 32'h92, 32'd0, 2'd0, 1'b0, 5'b00100, 5'd11, 1'b1, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        expect_out("flush", 1'b0, 1'b1, 32'h70, 32'h80, 32'h80, 5'b01001, 1'b0, 32'h800);
        check_out();
        bus.in_valid = 1'b1;
        bus.ex_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        expect_out("after_flush", 1'b1, 1'b1, 32'h91, 32'h92, 32'h92, 5'b00100, 1'b1, 32'h900);
        check_out();

        // reset overrides flush, capture and WB update
        rstn = 1'b0;
        bus.flush = 1'b1;
        bus.ex_ready = 1'b0;
        drive_instr(32'hA00, 5'd1, 5'd2, 32'hA1, 32'hA2, 32'd0, 2'd0, 1'b0, 5'b00101, 5'd12, 1'b1, 1'b0);
        bus.wb_rd = 5'd1; bus.wb_wen = 1'b1; bus.wb_data = 32'hFF;
        tick();
        clear_fwd();
        expect_out("reset_flush", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        check_out();
        rstn = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        expect_out("reset_release", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        check_out();

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
